// File: rtl/chacha20_stream_decoder.sv
// chacha20_stream_decoder: streaming ChaCha20 decryptor.
// Each accepted 512-bit ciphertext block is XORed with chacha20_block(state)
// and placed in a registered output stage. The 32-bit block counter
// (bits [415:384] of the state) advances once per accepted block.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A valid source holds its data stable until the transfer.
// ciphertext_ready_o is combinational from the FSM state, set_state_i, the
// registered plaintext_valid_o and plaintext_ready_i; it never depends on
// ciphertext_valid_i.
//
// Word i of a 512-bit state or block lives in bits [32*i+31:32*i]. Byte k
// of a data block lives in bits [8*k+7:8*k], so the little-endian keystream
// words line up with the message byte order.
module chacha20_stream_decoder (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic         clear_i,
  input  logic         set_state_i,
  input  logic [511:0] state_input_i,
  input  logic         ciphertext_valid_i,
  output logic         ciphertext_ready_o,
  input  logic [511:0] ciphertext_i,
  input  logic         ciphertext_last_i,
  output logic         plaintext_valid_o,
  input  logic         plaintext_ready_i,
  output logic [511:0] plaintext_o,
  output logic         plaintext_last_o,
  output logic         counter_wrap_o,
  output logic [1:0]   fsm_state_o,
  output logic [31:0]  counter_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fsm_t;

  // ChaCha quarter round on (a, b, c, d); returns {a, b, c, d}.
  function automatic logic [127:0] quarter_round(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [31:0] c,
                                                 input logic [31:0] d);
    logic [31:0] ta, tb, tc, td;
    ta = a + b;  td = d ^ ta; td = {td[15:0], td[31:16]};
    tc = c + td; tb = b ^ tc; tb = {tb[19:0], tb[31:20]};
    ta = ta + tb; td = td ^ ta; td = {td[23:0], td[31:24]};
    tc = tc + td; tb = tb ^ tc; tb = {tb[24:0], tb[31:25]};
    return {ta, tb, tc, td};
  endfunction

  // Full 20-round ChaCha block function, unrolled into combinational logic.
  function automatic logic [511:0] chacha20_block(input logic [511:0] s);
    logic [31:0]  x [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int d = 0; d < 10; d++) begin
      {x[0], x[4], x[8],  x[12]} = quarter_round(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = quarter_round(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = quarter_round(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = quarter_round(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = quarter_round(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = quarter_round(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = quarter_round(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = quarter_round(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
    return r;
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [511:0] cipher_state_q, cipher_state_d;
  logic [511:0] pt_q, pt_d;
  logic         pt_last_q, pt_last_d;
  logic         pt_valid_q, pt_valid_d;
  logic         wrap_q, wrap_d;

  logic [511:0] keystream;
  logic [31:0]  counter;
  logic         ct_ready;
  logic         accept;
  logic         drain;

  assign counter = cipher_state_q[415:384];

  // Keystream depends only on the registered cipher state.
  always_comb begin
    keystream = chacha20_block(cipher_state_q);
  end

  // Handshake terms: input is taken only in RUN, outside a re-key cycle,
  // and only when the output register is empty or emptying.
  always_comb begin
    ct_ready = (fsm_q == ST_RUN) && !set_state_i &&
               (!pt_valid_q || plaintext_ready_i);
    accept   = ciphertext_valid_i && ct_ready;
    drain    = pt_valid_q && plaintext_ready_i;
  end

  // FSM next state, cipher state update and wrap flag.
  always_comb begin
    fsm_d          = fsm_q;
    cipher_state_d = cipher_state_q;
    wrap_d         = wrap_q;
    if (set_state_i) begin
      cipher_state_d = state_input_i;
      fsm_d          = ST_RUN;
      wrap_d         = 1'b0;
    end else if (accept) begin
      cipher_state_d[415:384] = counter + 32'd1;
      if (counter == 32'hFFFF_FFFF) begin
        fsm_d  = ST_HALT;
        wrap_d = 1'b1;
      end else if (ciphertext_last_i) begin
        fsm_d = ST_FLUSH;
      end
    end else if ((fsm_q == ST_FLUSH) && drain) begin
      fsm_d = ST_IDLE;
    end
  end

  // Output register: reload on accept, otherwise empty on drain; data holds.
  always_comb begin
    pt_d       = pt_q;
    pt_last_d  = pt_last_q;
    pt_valid_d = pt_valid_q;
    if (accept) begin
      pt_d       = ciphertext_i ^ keystream;
      pt_last_d  = ciphertext_last_i;
      pt_valid_d = 1'b1;
    end else if (drain) begin
      pt_valid_d = 1'b0;
    end
  end

  // State registers; reset and soft clear both return everything to zero.
  always_ff @(posedge clock_i) begin
    if (!reset_ni || clear_i) begin
      fsm_q          <= ST_IDLE;
      cipher_state_q <= '0;
      pt_q           <= '0;
      pt_last_q      <= 1'b0;
      pt_valid_q     <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      cipher_state_q <= cipher_state_d;
      pt_q           <= pt_d;
      pt_last_q      <= pt_last_d;
      pt_valid_q     <= pt_valid_d;
      wrap_q         <= wrap_d;
    end
  end

  assign ciphertext_ready_o = ct_ready;
  assign plaintext_valid_o  = pt_valid_q;
  assign plaintext_o        = pt_q;
  assign plaintext_last_o   = pt_last_q;
  assign counter_wrap_o     = wrap_q;
  assign fsm_state_o        = fsm_q;
  assign counter_o          = counter;

endmodule

// File: tb/tb_chacha20_stream_decoder.sv
// Directed bench for chacha20_stream_decoder using RFC 8439 vectors.
module tb_chacha20_stream_decoder;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Clock / reset
  logic         clock_i = 1'b0;
  logic         reset_ni;
  logic         clear_i;
  logic         set_state_i;
  logic [511:0] state_input_i;
  logic         ciphertext_valid_i;
  logic         ciphertext_ready_o;
  logic [511:0] ciphertext_i;
  logic         ciphertext_last_i;
  logic         plaintext_valid_o;
  logic         plaintext_ready_i;
  logic [511:0] plaintext_o;
  logic         plaintext_last_o;
  logic         counter_wrap_o;
  logic [1:0]   fsm_state_o;
  logic [31:0]  counter_o;

  always #5 clock_i = ~clock_i;

  chacha20_stream_decoder dut (
    .clock_i            (clock_i),
    .reset_ni           (reset_ni),
    .clear_i            (clear_i),
    .set_state_i        (set_state_i),
    .state_input_i      (state_input_i),
    .ciphertext_valid_i (ciphertext_valid_i),
    .ciphertext_ready_o (ciphertext_ready_o),
    .ciphertext_i       (ciphertext_i),
    .ciphertext_last_i  (ciphertext_last_i),
    .plaintext_valid_o  (plaintext_valid_o),
    .plaintext_ready_i  (plaintext_ready_i),
    .plaintext_o        (plaintext_o),
    .plaintext_last_o   (plaintext_last_o),
    .counter_wrap_o     (counter_wrap_o),
    .fsm_state_o        (fsm_state_o),
    .counter_o          (counter_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected-value scoreboard for the vectors (filled in the initial block)
  logic [511:0] s1, s2, s3;
  logic [511:0] c1, c2, p1, p2, k2;
  logic [511:0] p1_str;
  logic [399:0] p2_str;

  // Reorders a block written first-byte-leftmost into byte k at [8k+7:8k].
  function automatic logic [511:0] rev_bytes(input logic [511:0] v);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = v[511-8*k -: 8];
    return r;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ni = 1'b0; clear_i = 1'b0; set_state_i = 1'b0; state_input_i = '0;
    ciphertext_valid_i = 1'b0; ciphertext_i = '0; ciphertext_last_i = 1'b0;
    plaintext_ready_i = 1'b0;

    s1 = {32'h0, 32'h4a000000, 32'h0, 32'h1,
          32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
          32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
          32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    s2 = s1;
    s2[447:416] = 32'h09000000;
    s3 = s1;
    s3[415:384] = 32'hfffffffe;
    c1 = rev_bytes(512'h6e2e359a2568f98041ba0728dd0d6981_e97e7aec1d4360c20a27afccfd9fae0b_f91b65c5524733ab8f593dabcd62b357_1639d624e65152ab8f530c359f0861d8);
    c2 = rev_bytes(512'h07ca0dbf500d6a6156a38e088a22b65e_52bc514d16ccf806818ce91ab7793736_5af90bbf74a35be6b40b8eedf2785e42_874d0000000000000000000000000000);
    p1_str = "Ladies and Gentlemen of the class of '99: If I could offer you o";
    p2_str = "nly one tip for the future, sunscreen would be it.";
    p1 = rev_bytes(p1_str);
    p2 = rev_bytes({p2_str, 112'h0});
    k2 = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
          32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
          32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
          32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    // Reset state
    tick(); tick();
    chk("rst_pvalid", plaintext_valid_o, 1'b0);
    chk("rst_pt", plaintext_o, '0);
    chk("rst_ready", ciphertext_ready_o, 1'b0);
    chk("rst_wrap", counter_wrap_o, 1'b0);
    chk("rst_fsm", fsm_state_o, S_IDLE);
    chk("rst_counter", counter_o, 32'd0);
    reset_ni = 1'b1;

    // IDLE guard: offered ciphertext is never taken without a key
    ciphertext_valid_i = 1'b1; ciphertext_i = c1; plaintext_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("idle_ready", ciphertext_ready_o, 1'b0);
      tick();
      chk("idle_pvalid", plaintext_valid_o, 1'b0);
    end
    ciphertext_valid_i = 1'b0;

    // RFC 8439 2.4.2: two blocks back to back, last on the second
    set_state_i = 1'b1; state_input_i = s1;
    #1 chk("rfc_ready_setstate", ciphertext_ready_o, 1'b0);
    tick();
    set_state_i = 1'b0;
    chk("rfc_fsm_run", fsm_state_o, S_RUN);
    chk("rfc_counter1", counter_o, 32'd1);
    ciphertext_valid_i = 1'b1; ciphertext_i = c1; ciphertext_last_i = 1'b0;
    #1 chk("rfc_ready1", ciphertext_ready_o, 1'b1);
    tick();
    ciphertext_i = c2; ciphertext_last_i = 1'b1;
    chk("rfc_pt1", plaintext_o, p1);
    chk("rfc_pvalid1", plaintext_valid_o, 1'b1);
    chk("rfc_plast1", plaintext_last_o, 1'b0);
    #1 chk("rfc_ready2", ciphertext_ready_o, 1'b1);
    tick();
    ciphertext_valid_i = 1'b0; ciphertext_last_i = 1'b0;
    chk("rfc_pt2", plaintext_o[399:0], p2[399:0]);
    chk("rfc_plast2", plaintext_last_o, 1'b1);
    chk("rfc_counter3", counter_o, 32'd3);
    chk("rfc_fsm_flush", fsm_state_o, S_FLUSH);
    #1 chk("rfc_ready_flush", ciphertext_ready_o, 1'b0);
    tick();
    chk("rfc_drained", plaintext_valid_o, 1'b0);
    chk("rfc_fsm_idle", fsm_state_o, S_IDLE);

    // Backpressure: one block taken, then held for 5 cycles
    set_state_i = 1'b1; state_input_i = s1;
    tick();
    set_state_i = 1'b0;
    plaintext_ready_i = 1'b0;
    ciphertext_valid_i = 1'b1; ciphertext_i = c1;
    tick();
    ciphertext_i = c2; ciphertext_last_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", ciphertext_ready_o, 1'b0);
      chk("bp_pt_stable", plaintext_o, p1);
      chk("bp_counter", counter_o, 32'd2);
      tick();
    end
    plaintext_ready_i = 1'b1;
    #1 chk("bp_ready_release", ciphertext_ready_o, 1'b1);
    tick();
    ciphertext_valid_i = 1'b0; ciphertext_last_i = 1'b0;
    chk("bp_pvalid_reload", plaintext_valid_o, 1'b1);
    chk("bp_pt2", plaintext_o[399:0], p2[399:0]);
    chk("bp_counter3", counter_o, 32'd3);
    tick();
    chk("bp_fsm_idle", fsm_state_o, S_IDLE);

    // Re-key while an output block is pending
    set_state_i = 1'b1; state_input_i = s1;
    tick();
    set_state_i = 1'b0;
    plaintext_ready_i = 1'b0;
    ciphertext_valid_i = 1'b1; ciphertext_i = c1;
    tick();
    set_state_i = 1'b1; state_input_i = s2; ciphertext_i = '0;
    #1 chk("rk_ready_setstate", ciphertext_ready_o, 1'b0);
    tick();
    set_state_i = 1'b0;
    chk("rk_pending_valid", plaintext_valid_o, 1'b1);
    chk("rk_pending_pt", plaintext_o, p1);
    chk("rk_counter_loaded", counter_o, 32'd1);
    plaintext_ready_i = 1'b1;
    #1 chk("rk_ready", ciphertext_ready_o, 1'b1);
    tick();
    ciphertext_valid_i = 1'b0;
    chk("rk_new_key_pt", plaintext_o, k2);
    chk("rk_counter2", counter_o, 32'd2);
    tick();
    chk("rk_drained", plaintext_valid_o, 1'b0);

    // Reset mid-stream with a block pending
    plaintext_ready_i = 1'b0; ciphertext_valid_i = 1'b1; ciphertext_i = '0;
    tick();
    chk("mr_pending", plaintext_valid_o, 1'b1);
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    chk("mr_pvalid", plaintext_valid_o, 1'b0);
    chk("mr_pt", plaintext_o, '0);
    chk("mr_ready", ciphertext_ready_o, 1'b0);
    chk("mr_fsm", fsm_state_o, S_IDLE);
    chk("mr_counter", counter_o, 32'd0);

    // Soft clear with a block pending
    ciphertext_valid_i = 1'b0;
    set_state_i = 1'b1; state_input_i = s2;
    tick();
    set_state_i = 1'b0; ciphertext_valid_i = 1'b1;
    tick();
    chk("cl_pending_pt", plaintext_o, k2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("cl_pvalid", plaintext_valid_o, 1'b0);
    chk("cl_pt", plaintext_o, '0);
    chk("cl_ready", ciphertext_ready_o, 1'b0);
    chk("cl_fsm", fsm_state_o, S_IDLE);
    ciphertext_valid_i = 1'b0;

    // Counter wrap: start at 0xFFFFFFFE, offer three blocks
    set_state_i = 1'b1; state_input_i = s3;
    tick();
    set_state_i = 1'b0;
    plaintext_ready_i = 1'b1;
    ciphertext_valid_i = 1'b1; ciphertext_i = '0; ciphertext_last_i = 1'b0;
    #1 chk("wr_ready1", ciphertext_ready_o, 1'b1);
    tick();
    chk("wr_counter_ff", counter_o, 32'hffffffff);
    chk("wr_flag_early", counter_wrap_o, 1'b0);
    ciphertext_last_i = 1'b1;
    #1 chk("wr_ready2", ciphertext_ready_o, 1'b1);
    tick();
    chk("wr_flag", counter_wrap_o, 1'b1);
    chk("wr_counter0", counter_o, 32'd0);
    chk("wr_fsm_halt", fsm_state_o, S_HALT);
    chk("wr_plast", plaintext_last_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wr_ready_halt", ciphertext_ready_o, 1'b0);
      tick();
      chk("wr_no_accept", counter_o, 32'd0);
    end
    chk("wr_drained", plaintext_valid_o, 1'b0);
    ciphertext_valid_i = 1'b0; ciphertext_last_i = 1'b0;
    set_state_i = 1'b1; state_input_i = s1;
    tick();
    set_state_i = 1'b0;
    chk("wr_flag_cleared", counter_wrap_o, 1'b0);
    chk("wr_fsm_run", fsm_state_o, S_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chacha20_stream_decoder.md
# chacha20_stream_decoder

Streaming ChaCha20 decryptor for the receive side of the serial cipher path. It accepts 512-bit ciphertext blocks over a valid/ready handshake and XORs each block with the keystream from a `chacha20_block` instance. It advances the 32-bit block counter once per accepted block, not once per cycle, and returns plaintext through a registered, backpressure-aware output stage.

## Interface
- No parameters; the block width is fixed at 512 bits and the counter at 32 bits.
- clock  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-low reset.
- clear  in  1  Synchronous, active-high soft clear; same effect as reset; reset has priority.
- set_state  in  1  Load `state_input` into the cipher state register.
- state_input  in  512  Initial ChaCha20 state in the standard word order (constants, key, counter, nonce). The counter word is bits [415:384].
- ciphertext_valid  in  1  Ciphertext block offered.
- ciphertext_ready  out  1  Block accepted on a cycle where valid and ready are both 1.
- ciphertext  in  512  Ciphertext block.
- ciphertext_last  in  1  Marks the final block of a message.
- plaintext_valid  out  1  Output register holds a block.
- plaintext_ready  in  1  Downstream accepts the output.
- plaintext  out  512  Decrypted block.
- plaintext_last  out  1  Copy of `ciphertext_last` for this block.
- counter_wrap  out  1  Sticky flag: a block was accepted with counter = 0xFFFFFFFF.

## Operation
- FSM states:
  - IDLE: no valid key.
  - RUN: accepting blocks.
  - FLUSH: the last block has been accepted and the output is not yet drained.
  - HALT: the counter has wrapped.
- Keystream is `chacha20_block(state_q)`, which is combinational. Accept condition: `ciphertext_valid & ciphertext_ready`.
- ciphertext_ready = (state==RUN) & !set_state & (!plaintext_valid | plaintext_ready).
- On accept:
  - plaintext ← ciphertext ^ keystream.
  - plaintext_last ← ciphertext_last.
  - plaintext_valid ← 1.
  - state_q[415:384] ← state_q[415:384] + 1 mod 2^32; all other state bits unchanged.
- If plaintext_valid & plaintext_ready and no accept occurs that cycle: plaintext_valid ← 0. The plaintext data and last registers hold their value.
- FSM transitions:
  - IDLE → RUN on set_state.
  - RUN → FLUSH on an accept with ciphertext_last=1.
  - RUN → HALT on an accept with counter = 0xFFFFFFFF, even if last=1; counter_wrap ← 1.
  - FLUSH → IDLE when the output drains (plaintext_valid & plaintext_ready).
  - HALT → RUN on set_state.
- set_state in any state:
  - state_q ← state_input and FSM → RUN.
  - counter_wrap is cleared.
  - The output register is untouched; a pending block stays valid and is delivered.
  - No ciphertext is accepted in that cycle.
- In FLUSH, set_state re-keys and moves to RUN; the pending output is still delivered.
- Reset or clear:
  - FSM → IDLE; state_q ← 0.
  - plaintext_valid, plaintext, plaintext_last and counter_wrap ← 0; ciphertext_ready is 0.
  - Mid-stream data in the output register is discarded.

## Timing
- Latency is 1 cycle: a block accepted at edge N is presented as plaintext_valid=1 after edge N.
- Full throughput is 1 block/cycle while plaintext_ready is held at 1.
- Backpressure: with plaintext_valid=1 and plaintext_ready=0, ciphertext_ready=0 the same cycle (combinational from registered valid and the ready input). The output is held stable until taken.
- Simultaneous drain and accept in one cycle: the output register is reloaded and plaintext_valid stays 1.
- ciphertext_ready is 0 in IDLE, FLUSH and HALT, and during any cycle with set_state=1.
- The keystream path is purely combinational from state_q. state_q is only modified on accept or set_state.
- Counter arithmetic is 32-bit unsigned and wraps to 0. The 0xFFFFFFFF block itself is decrypted correctly.

## Test plan
- RFC 8439 §2.4.2 vector (key 00..1f, nonce 000000000000004a00000000, counter 1):
  - Stimulus: set_state, then two ciphertext blocks back-to-back with last on the 2nd, plaintext_ready=1.
  - Response: plaintext equals "Ladies and Gentlemen of the class of '99…" blocks one cycle after each accept; counter reads 3; FSM reaches IDLE after the drain.
- Backpressure:
  - Stimulus: plaintext_ready=0 for 5 cycles while ciphertext_valid=1.
  - Response: exactly 1 block is accepted; ciphertext_ready=0 for those cycles; plaintext is stable. Releasing ready resumes 1 block/cycle with no loss or duplication.
- Counter wrap:
  - Stimulus: set_state with counter word 0xFFFFFFFE, then 3 offered blocks.
  - Response: 2 blocks accepted; counter_wrap=1; counter reads 0x00000000; ciphertext_ready stays 0 until set_state, which clears counter_wrap.
- Re-key with pending output:
  - Stimulus: set_state while plaintext_valid=1 and plaintext_ready=0.
  - Response: the pending block is delivered unchanged; no accept occurs in the set_state cycle; the next block decrypts under the new key and counter.
- Reset mid-stream:
  - Stimulus: reset=0 for one cycle with plaintext_valid=1.
  - Response: next cycle plaintext_valid=0, plaintext=0, ciphertext_ready=0, FSM in IDLE. clear=1 produces an identical result.
- IDLE guard:
  - Stimulus: ciphertext_valid=1 with no prior set_state.
  - Response: ciphertext_ready stays 0 indefinitely; plaintext_valid stays 0.
